td4x_core: RTL and testbench

Parametrised successor to the 4-bit TD4 CPU-plus-program-memory top. Generalises data width and program depth, and replaces the free-running exec mode with a run-control FSM: clock-divided run, single-step, self-loop halt and an optional PC breakpoint. Sits below the chip top wrapper, which maps pads onto these ports.

---
 rtl/td4x_pkg.sv | 32 +++
 rtl/td4x_progmem.sv | 46 ++++
 rtl/td4x_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_td4x_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/td4x_pkg.sv
// td4x_pkg: shared encodings for the TD4X core.
//   - opcode constants for the 4-bit instruction field
//   - run-control mode encoding driven by the mode input
//   - run-control FSM state enum (also exported on the state port)
package td4x_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;  // A = A + imm
  localparam logic [3:0] OP_MOV_AB = 4'b0001;  // A = B
  localparam logic [3:0] OP_IN_A   = 4'b0010;  // A = in_port
  localparam logic [3:0] OP_MOV_A  = 4'b0011;  // A = imm
  localparam logic [3:0] OP_MOV_BA = 4'b0100;  // B = A
  localparam logic [3:0] OP_ADD_B  = 4'b0101;  // B = B + imm
  localparam logic [3:0] OP_IN_B   = 4'b0110;  // B = in_port
  localparam logic [3:0] OP_MOV_B  = 4'b0111;  // B = imm
  localparam logic [3:0] OP_OUT_B  = 4'b1001;  // OUT = B
  localparam logic [3:0] OP_OUT_IM = 4'b1011;  // OUT = imm
  localparam logic [3:0] OP_JNC    = 4'b1110;  // jump if carry clear
  localparam logic [3:0] OP_JMP    = 4'b1111;  // unconditional jump

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_READ = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_HALT      = 2'b11
  } state_e;

endpackage

// File: rtl/td4x_progmem.sv
// td4x_progmem: program store of 2**ADDR_W entries of {op[3:0], imm}.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears every entry)
//   we_i            write strobe (already qualified by LOAD mode in the core)
//   waddr_i         write address
//   wop_i, wimm_i   entry written on the clock edge
//   raddr_i         combinational read address
//   rop_o, rimm_o   entry at raddr_i
module td4x_progmem #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [3:0]        wop_i,
  input  logic [DATA_W-1:0] wimm_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [3:0]        rop_o,
  output logic [DATA_W-1:0] rimm_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [3:0]        op_q  [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];

  // NOTE: the store is flop-based so that reset can clear every entry; a reset
  // clear rules out mapping onto RAM macros, which is acceptable at this depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        imm_q[i] <= '0;
      end
    end else if (we_i) begin
      op_q[waddr_i]  <= wop_i;
      imm_q[waddr_i] <= wimm_i;
    end
  end

  assign rop_o  = op_q[raddr_i];
  assign rimm_o = imm_q[raddr_i];

endmodule

// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-style CPU with program memory and run control.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mode                          00 LOAD, 01 READ, 10 RUN, 11 STEP
//   step                          level input; each rising edge executes one
//                                 instruction while in STEP_WAIT
//   prog_addr/prog_op/prog_imm    program write/inspect port
//   prog_we                       write strobe, honoured only in LOAD
//   rd_op, rd_imm                 entry at prog_addr (LOAD/READ) or at pc
//   in_port                       input port for IN A / IN B
//   bp_en, bp_addr                PC breakpoint (only with the macro below)
//   reg_a, reg_b, out_port, carry, pc   architectural state
//   state, halted                 run-control FSM state
// Build option: define TD4X_BREAKPOINT_EN to enable the PC breakpoint.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [3:0]        prog_op,
  input  logic [DATA_W-1:0] prog_imm,
  input  logic              prog_we,
  output logic [3:0]        rd_op,
  output logic [DATA_W-1:0] rd_imm,
  input  logic [DATA_W-1:0] in_port,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] out_port,
  output logic              carry,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state,
  output logic              halted
);

  if (DATA_W < ADDR_W) begin : g_bad_width
    $error("td4x_core: DATA_W must be >= ADDR_W");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("td4x_core: CLK_DIV must be >= 1");
  end

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                carry_q, carry_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                step_q;

  logic [3:0]          cur_op;
  logic [DATA_W-1:0]   cur_imm;
  logic [ADDR_W-1:0]   rd_addr;
  logic                prog_mode;
  logic                bp_hit;

  // ---------------------------------------------------------------------------
  // Program memory. Inspection modes read at prog_addr, execution reads at pc.
  // ---------------------------------------------------------------------------
  assign prog_mode = (mode == MODE_LOAD) || (mode == MODE_READ);
  assign rd_addr   = prog_mode ? prog_addr : pc_q;

  td4x_progmem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_progmem (
    .clk     (clk),
    .rst     (rst),
    .we_i    ((mode == MODE_LOAD) && prog_we),
    .waddr_i (prog_addr),
    .wop_i   (prog_op),
    .wimm_i  (prog_imm),
    .raddr_i (rd_addr),
    .rop_o   (cur_op),
    .rimm_o  (cur_imm)
  );

  assign rd_op  = cur_op;
  assign rd_imm = cur_imm;

`ifdef TD4X_BREAKPOINT_EN
  assign bp_hit = bp_en && (pc_q == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr};
  assign bp_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   sum_a, sum_b;
  logic              jump_taken;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] pc_next;

  assign sum_a      = {1'b0, a_q} + {1'b0, cur_imm};
  assign sum_b      = {1'b0, b_q} + {1'b0, cur_imm};
  // JNC looks at carry as it stood before this instruction updates it.
  assign jump_taken = (cur_op == OP_JMP) || ((cur_op == OP_JNC) && !carry_q);
  assign jump_tgt   = cur_imm[ADDR_W-1:0];
  assign pc_next    = jump_taken ? jump_tgt : pc_q + ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // Run-control FSM and datapath next-state
  // ---------------------------------------------------------------------------
  logic exec;
  logic clear;

  // NOTE: every signal written here gets its default first so that no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    exec    = 1'b0;
    clear   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end else if (mode == MODE_STEP) begin
          state_d = ST_STEP_WAIT;
          clear   = 1'b1;
        end
      end
      ST_RUN: begin
        if (mode == MODE_STEP) begin
          state_d = ST_STEP_WAIT;
        end else if (prog_mode) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bp_hit) begin
            state_d = ST_HALT;
          end else begin
            exec = 1'b1;
            // A jump onto itself would spin forever; stop instead.
            if (jump_taken && (jump_tgt == pc_q)) state_d = ST_HALT;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_STEP_WAIT: begin
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (prog_mode) begin
          state_d = ST_IDLE;
        end else if (step && !step_q) begin
          exec = 1'b1;
        end
      end
      ST_HALT: begin
        if (mode == MODE_STEP)  state_d = ST_STEP_WAIT;
        else if (prog_mode)     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;

    if (clear) begin
      pc_d    = '0;
      a_d     = '0;
      b_d     = '0;
      out_d   = '0;
      carry_d = 1'b0;
    end else if (exec) begin
      pc_d    = pc_next;
      carry_d = 1'b0;  // only the two ADDs leave carry set
      case (cur_op)
        OP_ADD_A: begin
          a_d     = sum_a[DATA_W-1:0];
          carry_d = sum_a[DATA_W];
        end
        OP_MOV_AB: a_d   = b_q;
        OP_IN_A:   a_d   = in_port;
        OP_MOV_A:  a_d   = cur_imm;
        OP_MOV_BA: b_d   = a_q;
        OP_ADD_B: begin
          b_d     = sum_b[DATA_W-1:0];
          carry_d = sum_b[DATA_W];
        end
        OP_IN_B:   b_d   = in_port;
        OP_MOV_B:  b_d   = cur_imm;
        OP_OUT_B:  out_d = b_q;
        OP_OUT_IM: out_d = cur_imm;
        default: ;  // jumps and undefined opcodes only move pc
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      div_q   <= div_d;
      step_q  <= step;
    end
  end

  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = carry_q;
  assign pc       = pc_q;
  assign state    = state_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4x_core.sv
// tb_td4x_core: directed self-checking bench for td4x_core.
// u_dut runs with CLK_DIV=1; u_div runs with CLK_DIV=4. They share all inputs
// except mode, so each is loaded and run independently.
module tb_td4x_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode, mode2;
  logic       step, prog_we, bp_en;
  logic [3:0] prog_addr, prog_op, prog_imm, in_port, bp_addr;

  logic [3:0] rd_op, rd_imm, reg_a, reg_b, out_port, pc;
  logic [1:0] state;
  logic       carry, halted;

  logic [3:0] rd_op2, rd_imm2, reg_a2, reg_b2, out_port2, pc2;
  logic [1:0] state2;
  logic       carry2, halted2;

  int errors = 0;
  int checks = 0;

  td4x_core #(.DATA_W(4), .ADDR_W(4), .CLK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .step(step),
    .prog_addr(prog_addr), .prog_op(prog_op), .prog_imm(prog_imm), .prog_we(prog_we),
    .rd_op(rd_op), .rd_imm(rd_imm), .in_port(in_port),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .reg_a(reg_a), .reg_b(reg_b), .out_port(out_port), .carry(carry),
    .pc(pc), .state(state), .halted(halted)
  );

  td4x_core #(.DATA_W(4), .ADDR_W(4), .CLK_DIV(4)) u_div (
    .clk(clk), .rst(rst), .mode(mode2), .step(step),
    .prog_addr(prog_addr), .prog_op(prog_op), .prog_imm(prog_imm), .prog_we(prog_we),
    .rd_op(rd_op2), .rd_imm(rd_imm2), .in_port(in_port),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .reg_a(reg_a2), .reg_b(reg_b2), .out_port(out_port2), .carry(carry2),
    .pc(pc2), .state(state2), .halted(halted2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] op, input logic [3:0] imm);
    prog_addr = a;
    prog_op   = op;
    prog_imm  = imm;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; mode2 = 2'b01; step = 1'b0; prog_we = 1'b0;
    bp_en = 1'b0; prog_addr = '0; prog_op = '0; prog_imm = '0;
    in_port = 4'h9; bp_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // ---- reset state ----
    check("rst_pc",     pc,     0);
    check("rst_a",      reg_a,  0);
    check("rst_state",  state,  0);
    check("rst_halted", halted, 0);
    check("rst_rd_op",  rd_op,  0);

    // ---- load program: MOV A,3; ADD A,14; JNC 0; OUT 5; JMP 4 ----
    load(4'd0, 4'b0011, 4'd3);
    check("load_visible_op", rd_op, 4'b0011);
    load(4'd1, 4'b0000, 4'd14);
    load(4'd2, 4'b1110, 4'd0);
    load(4'd3, 4'b1011, 4'd5);
    load(4'd4, 4'b1111, 4'd4);

    // ---- test 2: READ back, unwritten address, write ignored in READ ----
    mode = 2'b01;
    prog_addr = 4'd0; #1; check("rd0_op", rd_op, 4'b0011); check("rd0_imm", rd_imm, 3);
    prog_addr = 4'd1; #1; check("rd1_op", rd_op, 4'b0000); check("rd1_imm", rd_imm, 14);
    prog_addr = 4'd2; #1; check("rd2_op", rd_op, 4'b1110); check("rd2_imm", rd_imm, 0);
    prog_addr = 4'd3; #1; check("rd3_op", rd_op, 4'b1011); check("rd3_imm", rd_imm, 5);
    prog_addr = 4'd4; #1; check("rd4_op", rd_op, 4'b1111); check("rd4_imm", rd_imm, 4);
    load(4'd7, 4'b0101, 4'd9);  // prog_we in READ must be ignored
    check("rd7_op", rd_op, 0);
    check("rd7_imm", rd_imm, 0);

    // ---- test 1: RUN with CLK_DIV=1 ----
    mode = 2'b10;
    tick();  // entry edge
    check("run_entry_state", state, 1);
    check("run_entry_pc", pc, 0);
    tick();
    check("run_e1_a", reg_a, 3);
    check("run_e1_pc", pc, 1);
    tick();
    check("run_e2_a", reg_a, 1);
    check("run_e2_carry", carry, 1);
    tick();
    check("run_e3_jnc_pc", pc, 3);
    check("run_e3_carry", carry, 0);
    tick();
    check("run_e4_out", out_port, 5);
    check("run_e4_rd_op_at_pc", rd_op, 4'b1111);
    tick();
    check("run_e5_halted", halted, 1);
    check("run_e5_pc", pc, 4);
    check("run_e5_state", state, 3);
    tick();
    check("halt_hold_pc", pc, 4);
    check("halt_hold_state", state, 3);

    // ---- IDLE holds registers ----
    mode = 2'b01;
    tick();
    check("idle_state", state, 0);
    check("idle_hold_a", reg_a, 1);
    check("idle_hold_out", out_port, 5);

    // ---- test 3: single step ----
    mode = 2'b11;
    tick();
    check("step_entry_state", state, 2);
    check("step_entry_out_clr", out_port, 0);
    check("step_entry_pc", pc, 0);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1; tick();
      step = 1'b0;
      for (int k = 0; k < 5; k++) tick();
    end
    check("step3_pc", pc, 3);
    check("step3_a", reg_a, 1);
    step = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    step = 1'b0; tick();
    check("step_held_pc", pc, 4);
    check("step_held_out", out_port, 5);
    step = 1'b1; tick(); step = 1'b0; tick();
    check("step_selfloop_no_halt", state, 2);
    check("step_selfloop_pc", pc, 4);

    // ---- test 5: breakpoint at pc 3 ----
    mode = 2'b01; tick();
    bp_en = 1'b1; bp_addr = 4'd3;
    mode = 2'b10; tick();
    for (int k = 0; k < 5; k++) tick();
    check("bp_halted", halted, 1);
`ifdef TD4X_BREAKPOINT_EN
    check("bp_pc", pc, 3);
    check("bp_out", out_port, 0);
`else
    check("nobp_pc", pc, 4);
    check("nobp_out", out_port, 5);
`endif
    mode = 2'b11; tick();
    check("bp_to_step_state", state, 2);
    step = 1'b1; tick(); step = 1'b0; tick();
    check("bp_step_out", out_port, 5);
    check("bp_step_pc", pc, 4);
    bp_en = 1'b0;

    // ---- test 6: reset mid-run ----
    mode = 2'b01; tick();
    mode = 2'b10; tick();
    tick(); tick();
    check("pre_rst_pc", pc, 2);
    rst = 1'b1; mode = 2'b01;
    tick();
    rst = 1'b0;
    check("post_rst_pc", pc, 0);
    check("post_rst_a", reg_a, 0);
    check("post_rst_carry", carry, 0);
    check("post_rst_state", state, 0);
    for (int i = 0; i < 16; i++) begin
      prog_addr = 4'(i); #1;
      check("post_rst_mem", {rd_op, rd_imm}, 0);
    end

    // ---- test 4: CLK_DIV=4, four MOV B,imm ----
    mode2 = 2'b00;
    load(4'd0, 4'b0111, 4'd1);
    load(4'd1, 4'b0111, 4'd2);
    load(4'd2, 4'b0111, 4'd3);
    load(4'd3, 4'b0111, 4'd4);
    mode2 = 2'b10; tick();
    check("div_entry_b", reg_b2, 0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("div_b", reg_b2, 32'(c / 4));
    end
    check("div_pc", pc2, 3);
    tick(); tick(); tick();
    mode2 = 2'b11; tick();  // would-be execute edge: mode change wins
    check("div_modechg_state", state2, 2);
    check("div_modechg_b", reg_b2, 3);
    check("div_modechg_pc", pc2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
